// File: rtl/divider_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state encoding
// and the iteration-counter sizing rule.
package divider_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_FIX  = 3'd2,
    S_ZERO = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // A one-bit operand still needs a one-bit counter.
  function automatic int count_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and keep the trial difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             no_fit;

  assign shifted = {rem_in, bit_in};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};

  // A kept difference is always below the divisor, so any set bit above the
  // operand width means the trial subtraction failed.
  assign no_fit  = diff[WIDTH+1] | diff[WIDTH];
  assign q_bit   = ~no_fit;
  assign rem_out = no_fit ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Iterative restoring divider, signed or unsigned per operation, one quotient
// bit per clock with a start/done handshake.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CW = count_bits(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // Magnitudes are taken modulo 2^WIDTH, so the most negative value maps to
  // itself and still divides correctly as an unsigned pattern.
  assign a_mag = (sign && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign && b[WIDTH-1]) ? -b : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (pr),
    .bit_in  (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // busy stays high through the done cycle, so a start presented alongside
  // done is ignored and the next one is taken on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      dvd      <= '0;
      pr       <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy  <= 1'b1;
            neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sign & a[WIDTH-1];
            pr    <= '0;
            dvs   <= b_mag;
            count <= CW'(WIDTH - 1);
            if (b == '0) begin
              dvd   <= a;
              state <= S_ZERO;
            end else begin
              dvd      <= a_mag;
              div_zero <= 1'b0;
              state    <= S_CALC;
            end
          end
        end
        // Quotient bits shift in from the bottom as dividend bits leave the top.
        S_CALC: begin
          dvd <= {dvd[WIDTH-2:0], step_q};
          pr  <= step_rem;
          if (count == '0) begin
            state <= S_FIX;
          end else begin
            count <= count - CW'(1);
          end
        end
        S_FIX: begin
          quot  <= neg_q ? -dvd : dvd;
          rem   <= neg_r ? -pr : pr;
          state <= S_DONE;
        end
        S_ZERO: begin
          quot     <= '1;
          rem      <= dvd;
          div_zero <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative restoring integer divider, signed or unsigned, selectable per operation. Inverse of the combinational multiplier.
- Produces a quotient and remainder of the same width as the operands, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and uses a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- sign  in  1  1 = operands are two's-complement signed, 0 = unsigned; captured with start.
- a  in  WIDTH  dividend; captured with start.
- b  in  WIDTH  divisor; captured with start.
- busy  out  1  high from the edge after start is accepted until done deasserts.
- done  out  1  single-cycle pulse; quot/rem/div_zero valid from this cycle on.
- quot  out  WIDTH  quotient.
- rem  out  WIDTH  remainder.
- div_zero  out  1  set when the captured divisor was zero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, quot=0, rem=0, div_zero=0, internal registers cleared. Reset mid-operation aborts it; no done is produced.
- States:
  - IDLE: start=1 captures a, b, sign. It forms |a| and |b| when sign=1 and records neg_q = a_msb^b_msb and neg_r = a_msb. Go to ZERO if b==0, else to CALC with count=WIDTH-1.
  - CALC: one restoring step per cycle on {partial rem, dividend} shift registers. Trial subtract; the quotient bit is 1 if no borrow. count decrements; after the step at count=0, go to FIX. Duration is exactly WIDTH cycles.
  - FIX: apply signs. quot = neg_q ? -q : q; rem = neg_r ? -r : r. All arithmetic is modulo 2^WIDTH. Go to DONE.
  - ZERO: quot = all ones, rem = a (raw captured value), div_zero=1. Go to DONE.
  - DONE: done=1 for this one cycle, busy=1. Next state is IDLE.
- Latency:
  - Normal: start sampled at edge 0; done is high in the cycle after edge WIDTH+2 (WIDTH+3 states including DONE).
  - Divide-by-zero: done is high in the cycle after edge 2.
- Result semantics:
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - a == quot*b + rem holds modulo 2^WIDTH.
- Signed overflow (a = -2^(WIDTH-1), b = -1): quot = -2^(WIDTH-1) (wraps), rem=0, no flag.
- start while busy=1 is ignored; operands are not re-captured.
- quot, rem and div_zero hold their values until the next accepted start. div_zero clears on acceptance of a start with b≠0.
- start may be asserted in the cycle after done, i.e. back-to-back, and is accepted in IDLE.
- The divider is combinationally independent of its inputs after capture; changing a, b or sign mid-operation has no effect.

Decomposition:
- Shared package: state encoding constants (S_IDLE, S_CALC, S_FIX, S_ZERO, S_DONE) and the counter width rule clog2(WIDTH). It is reused by future sequential arithmetic blocks.
- One natural sub-module, div_step: combinational single restoring step. Inputs are partial remainder, next dividend bit and divisor; outputs are the new remainder and quotient bit. It is instantiated once and unit-tested separately.
- Sign conditioning and fix-up stay in the top module.

Test Plan:
- sign=1, a=42, b=7 -> done after WIDTH+2 edges; quot=6, rem=0, div_zero=0; busy high throughout.
- sign=1, a=-42, b=5 -> quot=-8, rem=-2. Then a=100, b=-7 -> quot=-14, rem=2. Then a=-42, b=-5 -> quot=8, rem=-2.
- sign=0, a=8'd200, b=7 -> quot=28, rem=4. Same bits with sign=1 (a=-56) -> quot=-8, rem=0.
- sign=1, a=-128, b=-1 -> quot=-128, rem=0. Then b=0, a=13 -> done after 2 edges, quot=8'hFF, rem=13, div_zero=1. Next start with b=3 clears div_zero.
- Start with a=42, b=7; re-pulse start with a=9, b=3 mid-CALC -> result is still 6 r 0. Back-to-back start in the cycle after done is accepted.
- Start 42/7, drop rst_n at cycle 4 -> all outputs 0 immediately, no done pulse. Release reset; new 10/3 -> quot=3, rem=1.
